// File: rtl/logic_gate.sv
// logic_gate: registered bank of bitwise two-input logic functions
// (buffer, NOT, AND, OR, XOR, NAND, NOR) on WIDTH-bit operands.
// It also provides a one-cycle out_valid pulse and a saturating count of
// accepted samples.
// Optional feature macro: LOGIC_GATE_XNOR_EN adds a registered xnor_gate output.
//
// Handshake: en is a valid-only qualifier with no ready/backpressure. Every
// clk edge with en=1 (and rst=0) accepts a and b. The matching results and
// out_valid=1 appear exactly one cycle later. out_valid drops on any edge
// with en=0. rst has priority and discards the sample in its cycle.
module logic_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] buffer,
  output logic [WIDTH-1:0] not_gate,
  output logic [WIDTH-1:0] and_gate,
  output logic [WIDTH-1:0] or_gate,
  output logic [WIDTH-1:0] xor_gate,
  output logic [WIDTH-1:0] nand_gate,
  output logic [WIDTH-1:0] nor_gate,
`ifdef LOGIC_GATE_XNOR_EN
  output logic [WIDTH-1:0] xnor_gate,
`endif
  output logic             out_valid,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] buffer_q, buffer_d;
  logic [WIDTH-1:0] not_q,    not_d;
  logic [WIDTH-1:0] and_q,    and_d;
  logic [WIDTH-1:0] or_q,     or_d;
  logic [WIDTH-1:0] xor_q,    xor_d;
  logic [WIDTH-1:0] nand_q,   nand_d;
  logic [WIDTH-1:0] nor_q,    nor_d;
`ifdef LOGIC_GATE_XNOR_EN
  logic [WIDTH-1:0] xnor_q,   xnor_d;
`endif
  logic             valid_q,  valid_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Next-state: load fresh gate results on accept, otherwise hold.
  always_comb begin
    buffer_d = buffer_q;
    not_d    = not_q;
    and_d    = and_q;
    or_d     = or_q;
    xor_d    = xor_q;
    nand_d   = nand_q;
    nor_d    = nor_q;
`ifdef LOGIC_GATE_XNOR_EN
    xnor_d   = xnor_q;
`endif
    valid_d  = en;
    cnt_d    = cnt_q;
    if (en) begin
      buffer_d = a;
      not_d    = ~a;
      and_d    = a & b;
      or_d     = a | b;
      xor_d    = a ^ b;
      nand_d   = ~(a & b);
      nor_d    = ~(a | b);
`ifdef LOGIC_GATE_XNOR_EN
      xnor_d   = ~(a ^ b);
`endif
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // State registers; synchronous reset clears everything to zero, even the
  // inverting gates, and overrides a sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      buffer_q <= '0;
      not_q    <= '0;
      and_q    <= '0;
      or_q     <= '0;
      xor_q    <= '0;
      nand_q   <= '0;
      nor_q    <= '0;
`ifdef LOGIC_GATE_XNOR_EN
      xnor_q   <= '0;
`endif
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      buffer_q <= buffer_d;
      not_q    <= not_d;
      and_q    <= and_d;
      or_q     <= or_d;
      xor_q    <= xor_d;
      nand_q   <= nand_d;
      nor_q    <= nor_d;
`ifdef LOGIC_GATE_XNOR_EN
      xnor_q   <= xnor_d;
`endif
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign buffer     = buffer_q;
  assign not_gate   = not_q;
  assign and_gate   = and_q;
  assign or_gate    = or_q;
  assign xor_gate   = xor_q;
  assign nand_gate  = nand_q;
  assign nor_gate   = nor_q;
`ifdef LOGIC_GATE_XNOR_EN
  assign xnor_gate  = xnor_q;
`endif
  assign out_valid  = valid_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_logic_gate.sv
// tb_logic_gate: drives a WIDTH=1/CNT_W=8 instance and a WIDTH=8/CNT_W=2
// instance from shared rst/en. It compares both instances every cycle against
// a truth-table reference model through an expected-value queue.
// Honours LOGIC_GATE_XNOR_EN when the design is built with it.
module tb_logic_gate;

  // Packed expected record: {valid, gates1[7:0], gates8[63:0], cnt1[7:0], cnt8[1:0]}
  localparam int W = 1 + 8 + 64 + 8 + 2;
`ifdef LOGIC_GATE_XNOR_EN
  localparam int NG = 8;
`else
  localparam int NG = 7;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic       a1, b1;
  logic [7:0] a8, b8;

  logic [7:0] o1;
  logic [7:0] o8 [8];
  logic       v1, v8;
  logic [7:0] cnt1;
  logic [1:0] cnt8;

  logic_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a1), .b(b1),
    .buffer(o1[0]), .not_gate(o1[1]), .and_gate(o1[2]), .or_gate(o1[3]),
    .xor_gate(o1[4]), .nand_gate(o1[5]), .nor_gate(o1[6]),
`ifdef LOGIC_GATE_XNOR_EN
    .xnor_gate(o1[7]),
`endif
    .out_valid(v1), .sample_cnt(cnt1)
  );

  logic_gate #(.WIDTH(8), .CNT_W(2)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .a(a8), .b(b8),
    .buffer(o8[0]), .not_gate(o8[1]), .and_gate(o8[2]), .or_gate(o8[3]),
    .xor_gate(o8[4]), .nand_gate(o8[5]), .nor_gate(o8[6]),
`ifdef LOGIC_GATE_XNOR_EN
    .xnor_gate(o8[7]),
`endif
    .out_valid(v8), .sample_cnt(cnt8)
  );

`ifndef LOGIC_GATE_XNOR_EN
  assign o1[7] = 1'b0;
  assign o8[7] = 8'h00;
`endif

  // ---------------- reference model ----------------
  logic [W-1:0] exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m1;
  logic [7:0] m8 [8];
  int         mc1, mc8;
  logic       mv;

  // Truth table per gate, indexed by {a,b}.
  function automatic logic tt(int g, logic x, logic y);
    logic [3:0] t;
    case (g)
      0:       t = 4'b1100; // buffer
      1:       t = 4'b0011; // not
      2:       t = 4'b1000; // and
      3:       t = 4'b1110; // or
      4:       t = 4'b0110; // xor
      5:       t = 4'b0111; // nand
      6:       t = 4'b0001; // nor
      default: t = 4'b1001; // xnor
    endcase
    return t[{x, y}];
  endfunction

  function automatic string gname(int g);
    case (g)
      0: return "buffer";
      1: return "not";
      2: return "and";
      3: return "or";
      4: return "xor";
      5: return "nand";
      6: return "nor";
      default: return "xnor";
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic e, input logic x1, input logic y1,
                      input logic [7:0] x8, input logic [7:0] y8);
    logic [63:0] g8flat;
    rst = r; en = e; a1 = x1; b1 = y1; a8 = x8; b8 = y8;
    @(posedge clk);
    if (r) begin
      m1 = '0;
      for (int g = 0; g < 8; g++) m8[g] = '0;
      mc1 = 0; mc8 = 0; mv = 1'b0;
    end else if (e) begin
      for (int g = 0; g < 8; g++) begin
        m1[g] = tt(g, x1, y1);
        for (int i = 0; i < 8; i++) m8[g][i] = tt(g, x8[i], y8[i]);
      end
      mc1 = (mc1 < 255) ? mc1 + 1 : 255;
      mc8 = (mc8 < 3) ? mc8 + 1 : 3;
      mv  = 1'b1;
    end else begin
      mv = 1'b0;
    end
    for (int g = 0; g < 8; g++) g8flat[g*8 +: 8] = m8[g];
    exp_q.push_back({mv, m1, g8flat, 8'(mc1), 2'(mc8)});
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("dut1 out_valid", 64'(v1), 64'(e[W-1]));
        chk("dut8 out_valid", 64'(v8), 64'(e[W-1]));
        chk("dut1 sample_cnt", 64'(cnt1), 64'(e[9:2]));
        chk("dut8 sample_cnt", 64'(cnt8), 64'(e[1:0]));
        for (int g = 0; g < NG; g++) begin
          chk($sformatf("dut1 %s", gname(g)), 64'(o1[g]), 64'(e[74 + g]));
          chk($sformatf("dut8 %s", gname(g)), 64'(o8[g]), 64'(e[10 + g*8 +: 8]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    rst = 1'b1; en = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = '0; b8 = '0;
    mc1 = 0; mc8 = 0; mv = 1'b0; m1 = '0;
    for (int g = 0; g < 8; g++) m8[g] = '0;

    // Reset with en and operands active: everything must read zero.
    step(1, 1, 1, 1, 8'hFF, 8'hFF);
    step(1, 1, 1, 1, 8'hFF, 8'hFF);

    // Full truth table, one pair per cycle; count reaches 4 on dut1.
    step(0, 1, 0, 0, 8'h00, 8'h00);
    step(0, 1, 0, 1, 8'h00, 8'hFF);
    step(0, 1, 1, 0, 8'hFF, 8'h00);
    step(0, 1, 1, 1, 8'hFF, 8'hFF);

    // Hold: accept (1,0) then idle with changed operands.
    step(0, 1, 1, 0, 8'hF0, 8'hCC);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 8'h0F, 8'h33);

    // Saturation of the 2-bit counter, then reset over a live sample.
    step(1, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) step(0, 1, k[0], k[1], 8'hF0, 8'hCC);
    step(1, 1, 1, 1, 8'hA5, 8'h5A);
    step(0, 0, 1, 1, 8'hA5, 8'h5A);

    // Long back-to-back burst drives the 8-bit counter into saturation.
    for (int k = 0; k < 260; k++)
      step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));

    // Random mix of accept, hold and occasional reset.
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), 8'($urandom));

    repeat (2) @(negedge clk);
    #1;
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_gate.md
Name: logic_gate

Overview:
- Registered bank of basic two-input logic functions: buffer, NOT, AND, OR, XOR, NAND, NOR.
- All functions are computed bitwise on two WIDTH-bit operands.
- Results are captured on the clock edge with an input-valid qualifier, a matching output-valid flag, and a saturating count of accepted samples.
- Used as a small utility and bring-up block wherever registered gate primitives are needed.

Parameters:
- WIDTH, 1, operand and result width in bits (legal range 1..64).
- CNT_W, 8, width of the accepted-sample counter (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  input valid; operands are sampled on a clk edge where en=1.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- buffer  output  WIDTH  registered copy of a.
- not_gate  output  WIDTH  registered ~a.
- and_gate  output  WIDTH  registered a & b.
- or_gate  output  WIDTH  registered a | b.
- xor_gate  output  WIDTH  registered a ^ b.
- nand_gate  output  WIDTH  registered ~(a & b).
- nor_gate  output  WIDTH  registered ~(a | b).
- out_valid  output  1  high for exactly the one cycle after an accepted sample.
- sample_cnt  output  CNT_W  number of accepted samples since reset, saturating.

Behaviour:
- Clocking: one clock domain, clk, rising edge. Reset is synchronous and active-high: rst is sampled only on the clk rising edge, with no asynchronous path.
- Reset (rst=1 at the edge):
  - All seven gate outputs are cleared to all-zero, including not_gate, nand_gate and nor_gate.
  - out_valid is cleared to 0; sample_cnt is cleared to 0.
  - rst has priority over en.
  - A reset asserted mid-stream discards the sample presented in that cycle.
- Accept (rst=0, en=1 at the edge):
  - Each gate output is loaded with its function of the a and b values present at that edge.
  - out_valid becomes 1.
  - sample_cnt increments by 1, saturating at 2^CNT_W-1.
- Hold (rst=0, en=0 at the edge):
  - All gate outputs keep their last values; out_valid becomes 0; sample_cnt holds.
- Latency: exactly 1 cycle from the sampling edge to the updated outputs. There is no combinational path from a, b or en to any output.
- Back-to-back: en may stay high on consecutive cycles. Every cycle is accepted, out_valid stays high, and the outputs update every cycle.
- Width: all functions are strictly bitwise; bit i of each output depends only on a[i] and b[i]. There is no carry or cross-bit logic.
- Saturation: when sample_cnt is at its maximum, a further accept leaves it at the maximum (no wrap). The gate outputs and out_valid still update normally.
- Unknown inputs: X on a or b is not filtered and propagates to the affected bits when en=1.
- No internal state machine beyond the output registers, the valid flop and the counter.

Optional Feature:
- Macro: LOGIC_GATE_XNOR_EN.
- Defined: an extra output port xnor_gate (output, WIDTH bits) is present.
  - It is registered ~(a ^ b) with the same en, hold, latency and reset rules as the other gate outputs.
  - Its reset value is all-zero.
- Not defined: the xnor_gate port and its register do not exist, and the port list is exactly as listed above.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, a=1, b=1 -> all gate outputs 0, out_valid=0, sample_cnt=0.
- Truth table, WIDTH=1, en=1, applying one operand pair per cycle, each checked one cycle later:
  - a=0, b=0 -> buffer=0, not=1, and=0, or=0, xor=0, nand=1, nor=1.
  - a=0, b=1 -> buffer=0, not=1, and=0, or=1, xor=1, nand=1, nor=0.
  - a=1, b=0 -> buffer=1, not=0, and=0, or=1, xor=1, nand=1, nor=0.
  - a=1, b=1 -> buffer=1, not=0, and=1, or=1, xor=0, nand=0, nor=0.
  - After these four accepts, sample_cnt=4.
- Hold: after accepting a=1, b=0, drive en=0 and a=0, b=1 for 3 cycles -> outputs keep the a=1, b=0 results, out_valid=0, sample_cnt unchanged.
- Vector width: WIDTH=8, a=8'hF0, b=8'hCC -> and=8'hC0, or=8'hFC, xor=8'h3C, nand=8'h3F, nor=8'h03, not=8'h0F, buffer=8'hF0.
- Saturation and reset priority, CNT_W=2:
  - 5 consecutive accepts -> sample_cnt goes 1, 2, 3, 3, 3.
  - Then rst=1 together with en=1 -> next cycle sample_cnt=0 and all outputs 0.
- XNOR (LOGIC_GATE_XNOR_EN defined), WIDTH=1: pairs (0,0), (0,1), (1,0), (1,1) -> xnor_gate = 1, 0, 0, 1, each one cycle after its sample.
